// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 8x8 multiply sequencer driving a shared combinational ALU
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_sel,
    output logic [1:0]  alu_load_shift,
    input  logic [7:0]  alu_result,
    input  logic        alu_cout,
    input  logic        alu_zout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ADD   = 2'b10;
    localparam logic [1:0] SEL_LDSH  = 2'b00;
    localparam logic [1:0] LS_ZERO   = 2'b00;
    localparam logic [1:0] LS_PASS   = 2'b10;
    localparam logic [1:0] LS_SHR    = 2'b11;

    state_t     r_state;
    logic [7:0] r_mcand;
    logic [7:0] r_acc;
    logic [7:0] r_mq;
    logic       r_c;
    logic [2:0] r_cnt;

    // The zero flag carries no information the sequencer needs.
    logic w_unused_zout;
    assign w_unused_zout = alu_zout;

    // Status and product are pure decodes of registered state, so reset clears them at once.
    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        product = {r_acc, r_mq};
    end

    // ALU drive: add only when the current multiplier bit is set, otherwise pass acc or shift it.
    always_comb begin
        alu_a          = 8'h00;
        alu_b          = 8'h00;
        alu_sel        = SEL_LDSH;
        alu_load_shift = LS_ZERO;
        case (r_state)
            S_ADD: begin
                alu_a = r_acc;
                if (r_mq[0]) begin
                    alu_b   = r_mcand;
                    alu_sel = SEL_ADD;
                end else begin
                    alu_load_shift = LS_PASS;
                end
            end
            S_SHIFT: begin
                alu_a          = r_acc;
                alu_load_shift = LS_SHR;
            end
            default: begin
                alu_a          = 8'h00;
            end
        endcase
    end

    // Sequencer: 8 ADD/SHIFT pairs, carry re-enters acc[7] on each shift, acc[0] moves into mq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mcand <= 8'h00;
            r_acc   <= 8'h00;
            r_mq    <= 8'h00;
            r_c     <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= op_a;
                        r_mq    <= op_b;
                        r_acc   <= 8'h00;
                        r_c     <= 1'b0;
                        r_cnt   <= 3'd0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_acc   <= alu_result;
                    r_c     <= r_mq[0] ? alu_cout : 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_acc   <= {r_c, alu_result[6:0]};
                    r_mq    <= {r_acc[0], r_mq[7:1]};
                    r_c     <= 1'b0;
                    r_cnt   <= r_cnt + 3'd1;
                    r_state <= (r_cnt == 3'd7) ? S_DONE : S_ADD;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed and random checks of alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_sel;
    logic [1:0]  alu_load_shift;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        alu_zout;

    int n_pass  = 0;
    int n_total = 0;

    alu_mul_seq dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op_a           (op_a),
        .op_b           (op_b),
        .busy           (busy),
        .done           (done),
        .product        (product),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_sel        (alu_sel),
        .alu_load_shift (alu_load_shift),
        .alu_result     (alu_result),
        .alu_cout       (alu_cout),
        .alu_zout       (alu_zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU model
    always_comb begin
        logic [8:0] sum;
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        if (alu_sel == 2'b10) begin
            alu_result = sum[7:0];
            alu_cout   = sum[8];
        end else begin
            case (alu_load_shift)
                2'b10:   alu_result = alu_a;
                2'b11:   alu_result = {1'b0, alu_a[7:1]};
                default: alu_result = 8'h00;
            endcase
        end
        alu_zout = (alu_result == 8'h00);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one edge, sample 1 time unit later, and check the alu_b gating property.
    task automatic tick();
        @(posedge clk);
        #1;
        check("alu_b_gate", {15'd0, (alu_b == 8'h00) || (alu_sel == 2'b10 && product[0])}, 16'd1);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
    endtask

    // Called just after the accepting edge k; runs through edge k+17.
    task automatic finish(input string tag, input logic [15:0] exp, input bit hold,
                          input bit chk_add_pass, input bit chk_carry, input bit chg_a);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check({tag, "_busy_run"}, {15'd0, busy}, 16'd1);
            check({tag, "_done_early"}, {15'd0, done}, 16'd0);
            if (chk_add_pass && (i % 2 == 0)) begin
                check({tag, "_add_sel"}, {14'd0, alu_sel}, 16'd0);
                check({tag, "_add_ls"}, {14'd0, alu_load_shift}, 16'd2);
            end
            if (chk_carry && i == 3)
                check({tag, "_carry"}, {15'd0, dut.r_c}, 16'd1);
            if (chg_a && i == 5) op_a = 8'h09;
            tick();
        end
        check({tag, "_done"}, {15'd0, done}, 16'd1);
        check({tag, "_busy_done"}, {15'd0, busy}, 16'd1);
        check({tag, "_product"}, product, exp);
        tick();
        check({tag, "_busy_idle"}, {15'd0, busy}, 16'd0);
        check({tag, "_done_idle"}, {15'd0, done}, 16'd0);
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        #12;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_product", product, 16'h0000);
        check("rst_alu", {alu_a, alu_b}, 16'h0000);
        check("rst_ctl", {12'd0, alu_sel, alu_load_shift}, 16'h0000);
        rst = 1'b0;
        tick();

        // 13 x 11
        accept(8'h0D, 8'h0B);
        finish("m13x11", 16'h008F, 0, 0, 0, 0);

        // 255 x 255 with carry observation in the second ADD
        accept(8'hFF, 8'hFF);
        finish("mffxff", 16'hFE01, 0, 0, 1, 0);

        // zero operands
        accept(8'h00, 8'hA5);
        finish("m0xa5", 16'h0000, 0, 0, 0, 0);
        accept(8'h37, 8'h00);
        finish("m37x0", 16'h0000, 0, 1, 0, 0);

        // start held high; op_a changed mid-operation is ignored
        accept(8'h02, 8'h03);
        finish("hold", 16'h0006, 1, 0, 0, 1);
        tick();
        check("hold_restart_busy", {15'd0, busy}, 16'd1);
        check("hold_restart_prod", product, 16'h0003);
        finish("hold2", 16'h001B, 0, 0, 0, 0);

        // asynchronous reset during the 5th SHIFT
        accept(8'hFF, 8'hFF);
        start = 1'b0;
        repeat (9) tick();
        check("pre_rst_shift", {14'd0, alu_load_shift}, 16'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {15'd0, busy}, 16'd0);
        check("arst_done", {15'd0, done}, 16'd0);
        check("arst_product", product, 16'h0000);
        check("arst_alu", {alu_a, alu_b}, 16'h0000);
        check("arst_ctl", {12'd0, alu_sel, alu_load_shift}, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        accept(8'h10, 8'h10);
        finish("m10x10", 16'h0100, 0, 0, 0, 0);

        // random sweep
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            accept(ra, rb);
            finish("rand", 16'(ra) * 16'(rb), 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
